// File: rtl/bicubic_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bicubic_window_gen_pkg
// Description : Shared constants and window slice helper for bicubic_window_gen
// Revision    : 1.0 - initial release
// ============================================================================
package bicubic_window_gen_pkg;

    localparam int unsigned c_PIX_DW = 24;
    localparam int unsigned c_WIN_N  = 4;

    // Flat slot of window element (row i, column j) inside m_window
    function automatic int unsigned idx(input int unsigned i, input int unsigned j);
        return c_WIN_N * i + j;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bicubic_window_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : DEPTH-entry delay line advanced only on shift_en_i; dout_o is
//               the sample written exactly DEPTH shifts earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int DEPTH = 960,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift_en_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]   mem_q [DEPTH];
    logic [c_AW-1:0] ptr_q;
    logic [c_AW-1:0] ptr_d;

    assign ptr_d = (ptr_q == c_AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (shift_en_i) begin
            ptr_q <= ptr_d;
        end
    end

    // Read-before-write on the same slot gives the oldest sample
    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

    assign dout_o = mem_q[ptr_q];

endmodule
`default_nettype wire

// File: rtl/bicubic_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : bicubic_window_gen
// Description : Streaming 4x4 neighbourhood generator built from three line
//               buffers and a 4x4 window register array. Optional stall
//               counter port stall_cnt enabled by macro BWG_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bicubic_window_gen
    import bicubic_window_gen_pkg::*;
#(
    parameter int IMG_W = 960,
    parameter int IMG_H = 540,
    parameter int DW    = c_PIX_DW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DW-1:0]             s_data,
    input  logic                      s_sof,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [16*DW-1:0]          m_window,
    output logic [$clog2(IMG_H)-1:0]  m_row,
    output logic [$clog2(IMG_W)-1:0]  m_col,
    output logic                      m_last
`ifdef BWG_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic          w_acc;
    logic [CW-1:0] col_q, col_d, w_pos_col;
    logic [RW-1:0] row_q, row_d, w_pos_row;
    logic          w_col_end, w_row_end, w_gen;
    logic          m_valid_q;
    logic [RW-1:0] m_row_q;
    logic [CW-1:0] m_col_q;
    logic          m_last_q;

    logic [DW-1:0] w_lb_in  [3];
    logic [DW-1:0] w_lb_out [3];
    logic [DW-1:0] w_new_col [4];
    logic [DW-1:0] win_q [4][4];

    assign s_ready = ~m_valid_q | m_ready;
    assign w_acc   = s_valid & s_ready;

    // A start-of-frame pixel is placed at (0,0) regardless of the counters
    assign w_pos_row = s_sof ? '0 : row_q;
    assign w_pos_col = s_sof ? '0 : col_q;
    assign w_col_end = (w_pos_col == CW'(IMG_W - 1));
    assign w_row_end = (w_pos_row == RW'(IMG_H - 1));
    assign w_gen     = (w_pos_row >= RW'(3)) && (w_pos_col >= CW'(3));

    always_comb begin
        col_d = w_pos_col + 1'b1;
        row_d = w_pos_row;
        if (w_col_end) begin
            col_d = '0;
            row_d = w_row_end ? '0 : w_pos_row + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_row_q   <= '0;
            m_col_q   <= '0;
            m_last_q  <= 1'b0;
        end else begin
            if (w_acc) begin
                col_q     <= col_d;
                row_q     <= row_d;
                m_valid_q <= w_gen;
                if (w_gen) begin
                    m_row_q  <= w_pos_row;
                    m_col_q  <= w_pos_col;
                    m_last_q <= w_row_end && w_col_end;
                end
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    generate
        for (genvar gk = 0; gk < 3; gk++) begin : g_lb
            if (gk == 0) begin : g_first
                assign w_lb_in[gk] = s_data;
            end else begin : g_chain
                assign w_lb_in[gk] = w_lb_out[gk-1];
            end
            line_buffer #(
                .DEPTH (IMG_W),
                .DW    (DW)
            ) u_line_buffer (
                .clk        (clk),
                .rst        (rst),
                .shift_en_i (w_acc),
                .din_i      (w_lb_in[gk]),
                .dout_o     (w_lb_out[gk])
            );
        end
    endgenerate

    // Oldest row (r-3) enters window row 0, the live pixel enters row 3
    assign w_new_col[0] = w_lb_out[2];
    assign w_new_col[1] = w_lb_out[1];
    assign w_new_col[2] = w_lb_out[0];
    assign w_new_col[3] = s_data;

    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= win_q[i][j+1];
                end
                win_q[i][3] <= w_new_col[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_win_row
            for (genvar gj = 0; gj < 4; gj++) begin : g_win_col
                assign m_window[idx(gi, gj)*DW +: DW] = win_q[gi][gj];
            end
        end
    endgenerate

    assign m_valid = m_valid_q;
    assign m_row   = m_row_q;
    assign m_col   = m_col_q;
    assign m_last  = m_last_q;

`ifdef BWG_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (m_valid_q && !m_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bicubic_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_bicubic_window_gen
// Description : Scoreboard bench for bicubic_window_gen on an 8x6 image with
//               pixel value row*16+col.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bicubic_window_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid, s_ready, s_sof;
    logic [DW-1:0]     s_data;
    logic              m_valid, m_ready, m_last;
    logic [16*DW-1:0]  m_window;
    logic [2:0]        m_row, m_col;
`ifdef BWG_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    typedef struct packed {
        logic [127:0] win;
        logic [2:0]   row;
        logic [2:0]   col;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_win    = 0;
    int   n_last   = 0;

    bicubic_window_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_window (m_window),
        .m_row    (m_row),
        .m_col    (m_col),
        .m_last   (m_last)
`ifdef BWG_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] exp_win(input int r, input int c);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[(4*i+j)*8 +: 8] = 8'((r-3+i)*16 + (c-3+j));
        return w;
    endfunction

    // Monitor: sample mid-cycle, retire one expected window per handshake
    logic         prev_stall = 1'b0;
    logic [127:0] prev_win;
    logic [2:0]   prev_row, prev_col;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                check("s_ready", 128'(s_ready), 128'(!m_valid || m_ready));
                if (prev_stall) begin
                    check("stall_hold_valid", 128'(m_valid), 128'(1));
                    check("stall_hold_window", m_window, prev_win);
                    check("stall_hold_pos", {m_row, m_col}, {prev_row, prev_col});
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_window: got row %0d col %0d, required none", m_row, m_col);
                    end else begin
                        e = exp_q.pop_front();
                        check("window", m_window, e.win);
                        check("row_col", {m_row, m_col}, {e.row, e.col});
                        check("last", 128'(m_last), 128'(e.last));
                    end
                    n_win++;
                    if (m_last) n_last++;
                end
                prev_stall = m_valid && !m_ready;
                prev_win   = m_window;
                prev_row   = m_row;
                prev_col   = m_col;
            end
        end
    end

    task automatic send(input int r, input int c, input bit sof, input bit bubbles);
        bit ok;
        int t;
        if (bubbles) begin
            repeat ($urandom_range(0, 1)) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_sof   = 1'b0;
            end
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'(r*16 + c);
        s_sof   = sof;
        t = 0;
        forever begin
            #1 ok = s_ready;
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
            t++;
            if (t > 200) begin
                $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted, required acceptance", r, c);
                $fatal(1, "accept timeout");
            end
        end
        if (r >= 3 && c >= 3)
            exp_q.push_back('{exp_win(r, c), 3'(r), 3'(c), (r == H-1 && c == W-1)});
    endtask

    task automatic frame(input bit bubbles);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(r, c, (r == 0 && c == 0), bubbles);
    endtask

    task automatic drain();
        int t;
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    int base_win, base_last;

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        #12;
        check("reset_m_valid", 128'(m_valid), 128'(0));
        check("reset_m_row", 128'(m_row), 128'(0));
        check("reset_m_col", 128'(m_col), 128'(0));
        check("reset_m_last", 128'(m_last), 128'(0));
        check("reset_s_ready", 128'(s_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;

        // Full frame, no gaps
        base_win = n_win; base_last = n_last;
        frame(1'b0);
        drain();
        check("frame1_windows", 128'(n_win - base_win), 128'(15));
        check("frame1_last", 128'(n_last - base_last), 128'(1));

        // Five-cycle downstream stall mid-row
        base_win = n_win;
        fork
            frame(1'b0);
            begin
                int t;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!(m_valid && m_row == 3'd3 && m_col == 3'd4) && t < 200);
                m_ready = 1'b0;
                repeat (5) begin
                    #1 check("stall_s_ready", 128'(s_ready), 128'(0));
                    @(negedge clk);
                end
`ifdef BWG_STALL_CNT_EN
                check("stall_cnt", 128'(stall_cnt), 128'(5));
`endif
                m_ready = 1'b1;
            end
        join
        drain();
        check("stall_windows", 128'(n_win - base_win), 128'(15));

        // Random input bubbles
        base_win = n_win;
        frame(1'b1);
        drain();
        check("bubble_windows", 128'(n_win - base_win), 128'(15));

        // Two back-to-back frames
        base_win = n_win; base_last = n_last;
        frame(1'b0);
        frame(1'b0);
        drain();
        check("b2b_windows", 128'(n_win - base_win), 128'(30));
        check("b2b_last", 128'(n_last - base_last), 128'(2));

        // Partial frame, then s_sof at position (2,4) restarts counting
        base_win = n_win;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                if (r < 2 || c < 4) send(r, c, (r == 0 && c == 0), 1'b0);
        frame(1'b0);
        drain();
        check("sof_resync_windows", 128'(n_win - base_win), 128'(15));

        // Asynchronous reset mid-frame with a window pending
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < W; c++)
                if (r < 4 || c <= 4) send(r, c, (r == 0 && c == 0), 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        #1 check("pre_reset_valid", 128'(m_valid), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", 128'(m_valid), 128'(0));
        check("async_reset_pos", {m_row, m_col, m_last}, 7'd0);
`ifdef BWG_STALL_CNT_EN
        check("reset_stall_cnt", 128'(stall_cnt), 128'(0));
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        base_win = n_win;
        frame(1'b0);
        drain();
        check("post_reset_windows", 128'(n_win - base_win), 128'(15));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
